prco_alu: RTL and testbench

PRCO_ALU -- requirements
Module: prco_alu

---
 rtl/prco_alu_pkg.sv | 33 +++
 rtl/prco_mul16.sv | 52 +++++
 rtl/prco_alu.sv | 137 +++++++++++++
 tb/tb_prco_alu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/prco_alu_pkg.sv
// Shared ISA definitions for the PRCO ALU: opcode encodings, flag bit positions
// and the common Z/N flag packing helper.
package prco_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_MOV = 4'd5,
        OP_CMP = 4'd6,
        OP_LSL = 4'd7,
        OP_LSR = 4'd8,
        OP_MUL = 4'd9
    } op_e;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic [3:0] make_flags(input logic [15:0] res, input logic c, input logic v);
        logic [3:0] f;
        f         = 4'h0;
        f[FLAG_Z] = (res == 16'h0);
        f[FLAG_N] = res[15];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/prco_mul16.sv
// Iterative 16x16 shift-add multiplier: one partial product per enabled cycle,
// o_done marks the cycle whose accumulation completes the product on o_prod.
module prco_mul16 (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_start,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic        o_done,
    output logic [31:0] o_prod
);

    logic        r_run;
    logic [3:0]  r_cnt;
    logic [31:0] r_a;
    logic [15:0] r_b;
    logic [31:0] r_acc;
    logic [31:0] w_acc_next;

    assign w_acc_next = r_acc + (r_b[0] ? r_a : 32'h0);
    // The final sum is exposed combinationally so the caller can register it on
    // the same edge as the last iteration.
    assign o_prod     = w_acc_next;
    assign o_done     = r_run && (r_cnt == 4'd15);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_run <= 1'b0;
            r_cnt <= 4'd0;
            r_a   <= 32'h0;
            r_b   <= 16'h0;
            r_acc <= 32'h0;
        end else if (i_en) begin
            if (i_start) begin
                r_run <= 1'b1;
                r_cnt <= 4'd0;
                r_a   <= {16'h0, i_a};
                r_b   <= i_b;
                r_acc <= 32'h0;
            end else if (r_run) begin
                r_acc <= w_acc_next;
                r_a   <= r_a << 1;
                r_b   <= r_b >> 1;
                r_cnt <= r_cnt + 4'd1;
                if (r_cnt == 4'd15)
                    r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/prco_alu.sv
// PRCO ALU: single-cycle ops complete via WB one cycle after the strobe; MUL
// runs through the iterative multiplier before WB.
module prco_alu
    import prco_alu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_ce_alu,
    input  logic [3:0]  i_op,
    input  logic [2:0]  i_seld,
    input  logic        i_use_imm,
    input  logic [7:0]  i_imm8,
    input  logic [15:0] i_data,
    input  logic [15:0] i_datb,
    output logic        q_we,
    output logic [2:0]  q_seld,
    output logic [15:0] q_datd,
    output logic        q_ce_done,
    output logic [3:0]  q_flags,
    output logic        q_busy
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_WB} state_t;

    state_t      r_state, w_state_next;
    logic        r_we_pend;
    logic [2:0]  r_seld;
    logic [15:0] r_datd;
    logic [3:0]  r_flags;

    logic [15:0] w_b;
    logic        w_start;
    logic [16:0] w_sum17, w_diff17, w_shl17, w_shr17;
    logic [15:0] w_res;
    logic [3:0]  w_flags;
    logic        w_we;
    logic        w_wr;
    logic        w_mul_done;
    logic [31:0] w_mul_prod;

    assign w_b      = i_use_imm ? {8'h0, i_imm8} : i_datb;
    assign w_start  = i_en && (r_state == S_IDLE) && i_ce_alu;
    assign w_sum17  = {1'b0, i_data} + {1'b0, w_b};
    assign w_diff17 = {1'b0, i_data} - {1'b0, w_b};
    // Zero-extended shifts: the bit that falls off lands in bit 16 (LSL) or bit 0 (LSR).
    assign w_shl17  = {1'b0, i_data} << w_b[3:0];
    assign w_shr17  = {i_data, 1'b0} >> w_b[3:0];

    prco_mul16 u_mul (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_en),
        .i_start (w_start && (i_op == OP_MUL)),
        .i_a     (i_data),
        .i_b     (w_b),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
    );

    always_comb begin
        w_res   = 16'h0;
        w_flags = r_flags;
        w_we    = 1'b0;
        w_wr    = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_res   = w_sum17[15:0];
                w_flags = make_flags(w_res, w_sum17[16],
                                     (i_data[15] == w_b[15]) && (w_res[15] != i_data[15]));
                w_we = 1'b1; w_wr = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                w_res   = w_diff17[15:0];
                w_flags = make_flags(w_res, w_diff17[16],
                                     (i_data[15] != w_b[15]) && (w_res[15] != i_data[15]));
                w_we = (i_op == OP_SUB); w_wr = (i_op == OP_SUB);
            end
            OP_AND: begin w_res = i_data & w_b; w_flags = make_flags(w_res, 1'b0, 1'b0); w_we = 1'b1; w_wr = 1'b1; end
            OP_OR:  begin w_res = i_data | w_b; w_flags = make_flags(w_res, 1'b0, 1'b0); w_we = 1'b1; w_wr = 1'b1; end
            OP_XOR: begin w_res = i_data ^ w_b; w_flags = make_flags(w_res, 1'b0, 1'b0); w_we = 1'b1; w_wr = 1'b1; end
            OP_MOV: begin w_res = w_b; w_we = 1'b1; w_wr = 1'b1; end
            OP_LSL: begin w_res = w_shl17[15:0]; w_flags = make_flags(w_res, w_shl17[16], 1'b0); w_we = 1'b1; w_wr = 1'b1; end
            OP_LSR: begin w_res = w_shr17[16:1]; w_flags = make_flags(w_res, w_shr17[0], 1'b0); w_we = 1'b1; w_wr = 1'b1; end
            OP_MUL: w_we = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        if (i_en) begin
            case (r_state)
                S_IDLE: if (i_ce_alu) w_state_next = (i_op == OP_MUL) ? S_MUL : S_WB;
                S_MUL:  if (w_mul_done) w_state_next = S_WB;
                S_WB:   w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_we_pend <= 1'b0;
            r_seld    <= 3'd0;
            r_datd    <= 16'h0;
            r_flags   <= 4'h0;
        end else if (w_start) begin
            r_seld    <= i_seld;
            r_we_pend <= w_we;
            if (i_op != OP_MUL) begin
                if (w_wr)
                    r_datd <= w_res;
                r_flags <= w_flags;
            end
        end else if (i_en && (r_state == S_MUL) && w_mul_done) begin
            r_datd  <= w_mul_prod[15:0];
            r_flags <= make_flags(w_mul_prod[15:0], |w_mul_prod[31:16], 1'b0);
        end
    end

    // Completion is state-decoded, suppressed while frozen or being reset.
    assign q_ce_done = (r_state == S_WB) && i_en && !i_reset;
    assign q_we      = q_ce_done && r_we_pend;
    assign q_seld    = r_seld;
    assign q_datd    = r_datd;
    assign q_flags   = r_flags;
    assign q_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_prco_alu.sv
// Directed-vector bench for prco_alu with hand-computed expected results.
module tb_prco_alu;
    import prco_alu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset, i_en, i_ce_alu, i_use_imm;
    logic [3:0]  i_op;
    logic [2:0]  i_seld;
    logic [7:0]  i_imm8;
    logic [15:0] i_data, i_datb;
    logic        q_we, q_ce_done, q_busy;
    logic [2:0]  q_seld;
    logic [15:0] q_datd;
    logic [3:0]  q_flags;

    int n_checks = 0;
    int n_errors = 0;

    prco_alu dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_en      (i_en),
        .i_ce_alu  (i_ce_alu),
        .i_op      (i_op),
        .i_seld    (i_seld),
        .i_use_imm (i_use_imm),
        .i_imm8    (i_imm8),
        .i_data    (i_data),
        .i_datb    (i_datb),
        .q_we      (q_we),
        .q_seld    (q_seld),
        .q_datd    (q_datd),
        .q_ce_done (q_ce_done),
        .q_flags   (q_flags),
        .q_busy    (q_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Drives a one-cycle strobe; returns 1ns into the cycle after the strobe edge.
    task automatic strobe(input logic [3:0] op, input logic [2:0] sel, input logic ui,
                          input logic [7:0] imm, input logic [15:0] a, input logic [15:0] b);
        @(negedge i_clk);
        i_op = op; i_seld = sel; i_use_imm = ui; i_imm8 = imm; i_data = a; i_datb = b;
        i_ce_alu = 1'b1;
        @(posedge i_clk);
        #1;
        i_ce_alu = 1'b0;
        $display("txn op=%0d seld=%0d a=%h b=%h imm=%h use_imm=%0b", op, sel, a, b, imm, ui);
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [15:0] d, input logic [3:0] f);
        chk({tag, "_done"}, q_ce_done, 1'b1);
        chk({tag, "_we"}, q_we, we);
        chk({tag, "_datd"}, q_datd, d);
        chk({tag, "_flags"}, q_flags, f);
        tick();
        chk({tag, "_done_off"}, q_ce_done, 1'b0);
        chk({tag, "_idle"}, q_busy, 1'b0);
    endtask

    initial begin
        int n, busy_n, pulses, dn, bad;
        logic seen;
        logic [15:0] dd;
        logic [2:0]  ds;

        i_reset = 1'b1; i_en = 1'b1; i_ce_alu = 1'b0; i_use_imm = 1'b0;
        i_op = 4'h0; i_seld = 3'd0; i_imm8 = 8'h0; i_data = 16'h0; i_datb = 16'h0;
        tick(); tick();
        chk("rst_we", q_we, 1'b0);
        chk("rst_done", q_ce_done, 1'b0);
        chk("rst_seld", q_seld, 3'd0);
        chk("rst_datd", q_datd, 16'h0);
        chk("rst_flags", q_flags, 4'h0);
        chk("rst_busy", q_busy, 1'b0);
        @(negedge i_clk); i_reset = 1'b0;

        strobe(OP_ADD, 3'd3, 1'b0, 8'h00, 16'h7FFF, 16'h0001);
        chk("add_seld", q_seld, 3'd3);
        check_wb("add", 1'b1, 16'h8000, 4'b0101);

        strobe(OP_CMP, 3'd1, 1'b1, 8'h05, 16'h0003, 16'hFFFF);
        chk("cmp_done", q_ce_done, 1'b1);
        chk("cmp_we", q_we, 1'b0);
        chk("cmp_flags", q_flags, 4'b0110);
        tick();

        strobe(OP_SUB, 3'd2, 1'b0, 8'h00, 16'h0005, 16'h0003);
        check_wb("sub", 1'b1, 16'h0002, 4'b0000);
        strobe(OP_AND, 3'd2, 1'b0, 8'h00, 16'hF0F0, 16'h0FF0);
        check_wb("and", 1'b1, 16'h00F0, 4'b0000);
        strobe(OP_XOR, 3'd2, 1'b0, 8'h00, 16'hA5A5, 16'hA5A5);
        check_wb("xor", 1'b1, 16'h0000, 4'b1000);
        strobe(OP_OR, 3'd2, 1'b0, 8'h00, 16'h8000, 16'h0001);
        check_wb("or", 1'b1, 16'h8001, 4'b0100);
        strobe(OP_MOV, 3'd7, 1'b1, 8'h42, 16'h1234, 16'h0000);
        check_wb("mov", 1'b1, 16'h0042, 4'b0100);
        strobe(OP_LSR, 3'd2, 1'b1, 8'h01, 16'h0003, 16'h0000);
        check_wb("lsr1", 1'b1, 16'h0001, 4'b0010);
        strobe(OP_LSL, 3'd2, 1'b0, 8'h00, 16'h8001, 16'h0000);
        check_wb("lsl0", 1'b1, 16'h8001, 4'b0100);
        strobe(OP_LSL, 3'd2, 1'b1, 8'h01, 16'h8001, 16'h0000);
        check_wb("lsl1", 1'b1, 16'h0002, 4'b0010);

        strobe(4'hF, 3'd4, 1'b0, 8'h00, 16'h1111, 16'h2222);
        chk("nop_done", q_ce_done, 1'b1);
        chk("nop_we", q_we, 1'b0);
        chk("nop_flags", q_flags, 4'b0010);
        tick();

        // MUL latency and busy duration
        strobe(OP_MUL, 3'd6, 1'b0, 8'h00, 16'h0100, 16'h0100);
        n = 1; busy_n = 0; seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (q_busy) busy_n++;
            if (q_ce_done) begin seen = 1'b1; break; end
            tick();
            n++;
        end
        chk("mul_seen", seen, 1'b1);
        chk("mul_latency", n, 17);
        chk("mul_busy_cycles", busy_n, 17);
        chk("mul_seld", q_seld, 3'd6);
        check_wb("mul", 1'b1, 16'h0000, 4'b1010);

        // Second strobe mid-MUL must be ignored
        strobe(OP_MUL, 3'd5, 1'b0, 8'h00, 16'h0003, 16'h0007);
        pulses = 0; dn = 0; dd = 16'h0; ds = 3'd0;
        for (int k = 1; k <= 30; k++) begin
            if (q_ce_done) begin pulses++; dn = k; dd = q_datd; ds = q_seld; end
            if (k == 5) begin
                i_op = OP_ADD; i_data = 16'h0001; i_datb = 16'h0001; i_seld = 3'd2; i_use_imm = 1'b0;
                i_ce_alu = 1'b1;
            end else begin
                i_ce_alu = 1'b0;
            end
            tick();
        end
        $display("txn mul_with_ignored_strobe pulses=%0d", pulses);
        chk("mul2_pulses", pulses, 1);
        chk("mul2_latency", dn, 17);
        chk("mul2_datd", dd, 16'h0015);
        chk("mul2_seld", ds, 3'd5);
        chk("mul2_flags", q_flags, 4'b0000);

        // Reset 8 cycles into a MUL aborts it
        strobe(OP_MUL, 3'd1, 1'b0, 8'h00, 16'h0002, 16'h0003);
        bad = 0;
        for (int k = 1; k <= 25; k++) begin
            if (q_ce_done || q_we) bad++;
            if (k == 8) i_reset = 1'b1;
            if (k == 9) begin
                chk("abort_busy", q_busy, 1'b0);
                chk("abort_flags", q_flags, 4'h0);
                chk("abort_datd", q_datd, 16'h0);
                i_reset = 1'b0;
            end
            tick();
        end
        $display("txn mul_reset_abort stray_pulses=%0d", bad);
        chk("abort_no_pulse", bad, 0);
        strobe(OP_ADD, 3'd6, 1'b0, 8'h00, 16'h0002, 16'h0003);
        check_wb("add_after_abort", 1'b1, 16'h0005, 4'b0000);

        // Enable held low for 3 cycles while in WB
        strobe(OP_ADD, 3'd4, 1'b0, 8'h00, 16'h0001, 16'h0001);
        i_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("frz_done", q_ce_done, 1'b0);
            chk("frz_we", q_we, 1'b0);
            chk("frz_busy", q_busy, 1'b1);
            tick();
        end
        i_en = 1'b1;
        #1;
        $display("txn add_with_enable_stall");
        check_wb("frz_release", 1'b1, 16'h0002, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
